// File: rtl/hld_mux_pkg.sv
// Shared helpers for the HLD read-channel multiplexer: derived widths and tag extraction.
package hld_mux_pkg;

  // Widest port-ID field needed for up to 16 ports.
  localparam int unsigned MaxPortW = 4;

  function automatic int unsigned calc_port_w(input int unsigned n_ports);
    return (n_ports > 1) ? $clog2(n_ports) : 1;
  endfunction

  function automatic int unsigned calc_cred_w(input int unsigned max_out);
    return $clog2(max_out + 1);
  endfunction

  // Keep only the low port_w bits of a port-ID field, widened to MaxPortW.
  function automatic logic [MaxPortW-1:0] extract_tag(input logic [MaxPortW-1:0] field,
                                                      input int unsigned port_w);
    logic [MaxPortW-1:0] tag;
    for (int unsigned i = 0; i < MaxPortW; i++) begin
      tag[i] = (i < port_w) ? field[i] : 1'b0;
    end
    return tag;
  endfunction

endpackage

// File: rtl/hld_sync_fifo.sv
// Single-clock response FIFO; output word comes straight from storage (first-word fall-through).
module hld_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           push_i,
  input  logic [Width-1:0]               data_i,
  input  logic                           pop_i,
  output logic [Width-1:0]               data_o,
  output logic [$clog2(Depth+1)-1:0]     count_o,
  output logic                           full_o,
  output logic                           empty_o
);

  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW  = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  // Zero when empty so the data output is defined from reset onwards.
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == AddrW'(Depth - 1)) ? '0 : wr_ptr_q + AddrW'(1);
    if (do_pop)  rd_ptr_d = (rd_ptr_q == AddrW'(Depth - 1)) ? '0 : rd_ptr_q + AddrW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/hld_rd_channel_mux.sv
// N-port read-channel mux: round-robin request merge with port tagging, per-port credits,
// and per-port response FIFOs so the memory response channel is never back-pressured.
module hld_rd_channel_mux
  import hld_mux_pkg::*;
#(
  parameter int unsigned N_PORTS      = 3,
  parameter int unsigned REQ_W        = 80,
  parameter int unsigned RESP_W       = 528,
  parameter int unsigned REQ_TAG_LSB  = 0,
  parameter int unsigned RESP_TAG_LSB = 0,
  parameter int unsigned MAX_OUT      = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [N_PORTS-1:0]          acc_rd_req_valid_i,
  output logic [N_PORTS-1:0]          acc_rd_req_ready_o,
  input  logic [N_PORTS*REQ_W-1:0]    acc_rd_req_data_i,
  output logic                        mem_rd_req_valid_o,
  input  logic                        mem_rd_req_ready_i,
  output logic [REQ_W-1:0]            mem_rd_req_data_o,
  input  logic                        mem_rd_resp_valid_i,
  output logic                        mem_rd_resp_ready_o,
  input  logic [RESP_W-1:0]           mem_rd_resp_data_i,
  output logic [N_PORTS-1:0]          acc_rd_resp_valid_o,
  input  logic [N_PORTS-1:0]          acc_rd_resp_ready_i,
  output logic [N_PORTS*RESP_W-1:0]   acc_rd_resp_data_o,
  output logic                        idle_o,
  output logic                        tag_err_o
);

  localparam int unsigned PortW = calc_port_w(N_PORTS);
  localparam int unsigned CredW = calc_cred_w(MAX_OUT);

  logic                run_q;
  logic [N_PORTS-1:0]  eligible, grant;
  logic                grant_any, can_load;
  logic [PortW-1:0]    grant_idx, ptr_q, ptr_d;
  logic [REQ_W-1:0]    req_sel, out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic [CredW-1:0]    credit_q [N_PORTS];
  logic [CredW-1:0]    credit_d [N_PORTS];
  logic [CredW-1:0]    fifo_count [N_PORTS];
  logic [N_PORTS-1:0]  resp_push, resp_pop, fifo_full, fifo_empty;
  logic [MaxPortW-1:0] resp_tag;
  logic                resp_tag_ok, resp_in, tag_err_q, all_cred_full;

  // run_q keeps every handshake output low until the first edge after reset release.
  assign acc_rd_req_ready_o  = grant;
  assign mem_rd_req_valid_o  = out_valid_q;
  assign mem_rd_req_data_o   = out_data_q;
  assign mem_rd_resp_ready_o = run_q;
  assign acc_rd_resp_valid_o = ~fifo_empty;
  assign tag_err_o           = tag_err_q;
  assign idle_o              = all_cred_full && !out_valid_q;

  // Round-robin arbitration: ports at or above the pointer first, then wrap.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    can_load  = !out_valid_q || mem_rd_req_ready_i;
    for (int p = 0; p < int'(N_PORTS); p++) begin
      eligible[p] = acc_rd_req_valid_i[p] && (credit_q[p] != '0);
    end
    if (run_q && can_load) begin
      for (int p = 0; p < int'(N_PORTS); p++) begin
        if (!grant_any && eligible[p] && (p >= int'(ptr_q))) begin
          grant_any = 1'b1;
          grant[p]  = 1'b1;
          grant_idx = PortW'(p);
        end
      end
      for (int p = 0; p < int'(N_PORTS); p++) begin
        if (!grant_any && eligible[p] && (p < int'(ptr_q))) begin
          grant_any = 1'b1;
          grant[p]  = 1'b1;
          grant_idx = PortW'(p);
        end
      end
    end
    ptr_d = ptr_q;
    if (grant_any) begin
      ptr_d = (grant_idx == PortW'(N_PORTS - 1)) ? '0 : grant_idx + PortW'(1);
    end
  end

  // Output register: load tagged request on grant, clear once memory takes it.
  always_comb begin
    req_sel = '0;
    for (int p = 0; p < int'(N_PORTS); p++) begin
      if (grant[p]) req_sel = acc_rd_req_data_i[p*REQ_W +: REQ_W];
    end
    req_sel[REQ_TAG_LSB +: PortW] = grant_idx;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (grant_any) begin
      out_valid_d = 1'b1;
      out_data_d  = req_sel;
    end else if (mem_rd_req_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // Response steering and per-port credit accounting.
  always_comb begin
    resp_tag      = extract_tag(MaxPortW'(mem_rd_resp_data_i[RESP_TAG_LSB +: PortW]), PortW);
    resp_tag_ok   = (32'(resp_tag) < N_PORTS);
    resp_in       = run_q && mem_rd_resp_valid_i;
    all_cred_full = 1'b1;
    for (int p = 0; p < int'(N_PORTS); p++) begin
      resp_push[p] = resp_in && resp_tag_ok && (resp_tag == MaxPortW'(p));
      resp_pop[p]  = !fifo_empty[p] && acc_rd_resp_ready_i[p];
      credit_d[p]  = credit_q[p];
      if (grant[p] && !resp_pop[p]) begin
        credit_d[p] = credit_q[p] - CredW'(1);
      end else if (!grant[p] && resp_pop[p] && (credit_q[p] != CredW'(MAX_OUT))) begin
        // Saturate so stray post-reset responses cannot push a credit past the limit.
        credit_d[p] = credit_q[p] + CredW'(1);
      end
      if (credit_q[p] != CredW'(MAX_OUT)) all_cred_full = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q       <= 1'b0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      tag_err_q   <= 1'b0;
      for (int p = 0; p < int'(N_PORTS); p++) credit_q[p] <= CredW'(MAX_OUT);
    end else begin
      run_q       <= 1'b1;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      tag_err_q   <= tag_err_q | (resp_in && !resp_tag_ok);
      for (int p = 0; p < int'(N_PORTS); p++) credit_q[p] <= credit_d[p];
    end
  end

  for (genvar g = 0; g < int'(N_PORTS); g++) begin : g_port
    hld_sync_fifo #(
      .Width (RESP_W),
      .Depth (MAX_OUT)
    ) u_resp_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (resp_push[g]),
      .data_i  (mem_rd_resp_data_i),
      .pop_i   (resp_pop[g]),
      .data_o  (acc_rd_resp_data_o[g*RESP_W +: RESP_W]),
      .count_o (fifo_count[g]),
      .full_o  (fifo_full[g]),
      .empty_o (fifo_empty[g])
    );

    // Credits bound outstanding responses, so a push into a full FIFO means the
    // memory side returned more responses than were issued.
    a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                     !(resp_push[g] && fifo_full[g]));
    a_count_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                     32'(fifo_count[g]) <= MAX_OUT);
  end

endmodule

// File: tb/tb_hld_rd_channel_mux.sv
// Self-checking bench for hld_rd_channel_mux (3 ports, 16 outstanding).
module tb_hld_rd_channel_mux;

  localparam int unsigned N  = 3;
  localparam int unsigned RW = 80;
  localparam int unsigned SW = 528;
  localparam int unsigned MO = 16;

  logic              clk, rst_n;
  logic [N-1:0]      acc_rd_req_valid, acc_rd_req_ready;
  logic [N*RW-1:0]   acc_rd_req_data;
  logic              mem_rd_req_valid, mem_rd_req_ready;
  logic [RW-1:0]     mem_rd_req_data;
  logic              mem_rd_resp_valid, mem_rd_resp_ready;
  logic [SW-1:0]     mem_rd_resp_data;
  logic [N-1:0]      acc_rd_resp_valid, acc_rd_resp_ready;
  logic [N*SW-1:0]   acc_rd_resp_data;
  logic              idle, tag_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [RW-1:0] exp_req_q [$];
  logic [SW-1:0] exp_resp_q [N][$];

  typedef struct {
    logic [N-1:0] valid;
    logic         mem_rdy;
    logic [N-1:0] exp_grant;
    logic         exp_mem_valid;
  } arb_vec_t;

  arb_vec_t arb_tbl [13];

  hld_rd_channel_mux #(
    .N_PORTS      (N),
    .REQ_W        (RW),
    .RESP_W       (SW),
    .REQ_TAG_LSB  (0),
    .RESP_TAG_LSB (0),
    .MAX_OUT      (MO)
  ) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .acc_rd_req_valid_i  (acc_rd_req_valid),
    .acc_rd_req_ready_o  (acc_rd_req_ready),
    .acc_rd_req_data_i   (acc_rd_req_data),
    .mem_rd_req_valid_o  (mem_rd_req_valid),
    .mem_rd_req_ready_i  (mem_rd_req_ready),
    .mem_rd_req_data_o   (mem_rd_req_data),
    .mem_rd_resp_valid_i (mem_rd_resp_valid),
    .mem_rd_resp_ready_o (mem_rd_resp_ready),
    .mem_rd_resp_data_i  (mem_rd_resp_data),
    .acc_rd_resp_valid_o (acc_rd_resp_valid),
    .acc_rd_resp_ready_i (acc_rd_resp_ready),
    .acc_rd_resp_data_o  (acc_rd_resp_data),
    .idle_o              (idle),
    .tag_err_o           (tag_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req_data();
    for (int p = 0; p < int'(N); p++) begin
      logic [RW-1:0] d;
      d = RW'({$urandom(), $urandom(), $urandom()});
      acc_rd_req_data[p*RW +: RW] = d;
    end
  endtask

  function automatic logic [SW-1:0] mk_resp(input int unsigned tag);
    logic [SW-1:0] d;
    d = '0;
    for (int i = 0; i < int'(SW / 32); i++) d[i*32 +: 32] = $urandom();
    d[1:0] = 2'(tag);
    return d;
  endfunction

  task automatic do_reset();
    rst_n             = 1'b0;
    acc_rd_req_valid  = '0;
    mem_rd_req_ready  = 1'b1;
    mem_rd_resp_valid = 1'b0;
    acc_rd_resp_ready = '1;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  // Scoreboard: expectations pushed at input handshakes, popped at output handshakes.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_req_q.delete();
      for (int p = 0; p < int'(N); p++) exp_resp_q[p].delete();
    end else begin
      if (mem_rd_req_valid && mem_rd_req_ready) begin
        if (exp_req_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL mem_req_unexpected: actual request %0h required none", mem_rd_req_data);
        end else begin
          logic [RW-1:0] e;
          e = exp_req_q.pop_front();
          chk_w("mem_req_data", SW'(mem_rd_req_data), SW'(e));
        end
      end
      for (int p = 0; p < int'(N); p++) begin
        if (acc_rd_req_valid[p] && acc_rd_req_ready[p]) begin
          logic [RW-1:0] e;
          e = acc_rd_req_data[p*RW +: RW];
          e[1:0] = 2'(p);
          exp_req_q.push_back(e);
        end
        if (acc_rd_resp_valid[p] && acc_rd_resp_ready[p]) begin
          if (exp_resp_q[p].size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL acc_resp_unexpected: port %0d delivered data with none pending", p);
          end else begin
            logic [SW-1:0] e;
            e = exp_resp_q[p].pop_front();
            chk_w($sformatf("acc_resp_data[%0d]", p), acc_rd_resp_data[p*SW +: SW], e);
          end
        end
      end
      if (mem_rd_resp_valid && mem_rd_resp_ready && (mem_rd_resp_data[1:0] < 2'd3)) begin
        exp_resp_q[int'(mem_rd_resp_data[1:0])].push_back(mem_rd_resp_data);
      end
    end
  end

  initial begin
    int acc;
    logic [SW-1:0] d1, d2, d3;

    // {valid, mem_ready, expected grant, expected mem_rd_req_valid}
    arb_tbl[0]  = '{3'b111, 1'b1, 3'b001, 1'b0};
    arb_tbl[1]  = '{3'b111, 1'b1, 3'b010, 1'b1};
    arb_tbl[2]  = '{3'b111, 1'b1, 3'b100, 1'b1};
    arb_tbl[3]  = '{3'b111, 1'b1, 3'b001, 1'b1};
    arb_tbl[4]  = '{3'b111, 1'b1, 3'b010, 1'b1};
    arb_tbl[5]  = '{3'b111, 1'b1, 3'b100, 1'b1};
    arb_tbl[6]  = '{3'b101, 1'b1, 3'b001, 1'b1};
    arb_tbl[7]  = '{3'b101, 1'b1, 3'b100, 1'b1};
    arb_tbl[8]  = '{3'b011, 1'b0, 3'b000, 1'b1};
    arb_tbl[9]  = '{3'b011, 1'b1, 3'b001, 1'b1};
    arb_tbl[10] = '{3'b010, 1'b1, 3'b010, 1'b1};
    arb_tbl[11] = '{3'b000, 1'b1, 3'b000, 1'b1};
    arb_tbl[12] = '{3'b011, 1'b1, 3'b001, 1'b0};

    acc_rd_req_data  = '0;
    mem_rd_resp_data = '0;
    do_reset();
    chk("post_reset_idle", 32'(idle), 32'(1));
    chk("post_reset_resp_ready", 32'(mem_rd_resp_ready), 32'(1));

    // Round-robin arbitration table.
    for (int i = 0; i < 13; i++) begin
      acc_rd_req_valid = arb_tbl[i].valid;
      mem_rd_req_ready = arb_tbl[i].mem_rdy;
      drive_req_data();
      #1;
      chk($sformatf("arb_grant[%0d]", i), 32'(acc_rd_req_ready), 32'(arb_tbl[i].exp_grant));
      chk($sformatf("arb_mem_valid[%0d]", i), 32'(mem_rd_req_valid),
          32'(arb_tbl[i].exp_mem_valid));
      tick();
    end
    acc_rd_req_valid = '0;
    mem_rd_req_ready = 1'b1;
    repeat (2) tick();
    chk("req_sb_drained", 32'(exp_req_q.size()), 32'(0));
    chk("mem_valid_drained", 32'(mem_rd_req_valid), 32'(0));
    chk("idle_with_outstanding", 32'(idle), 32'(0));

    // Credit exhaustion on port 1.
    do_reset();
    acc_rd_req_valid = 3'b010;
    for (int i = 0; i < 20; i++) begin
      drive_req_data();
      #1;
      chk($sformatf("p1_credit_ready[%0d]", i), 32'(acc_rd_req_ready[1]), 32'(i < 16));
      tick();
    end
    acc_rd_req_valid = 3'b111;
    for (int i = 0; i < 4; i++) begin
      drive_req_data();
      #1;
      chk("p1_blocked", 32'(acc_rd_req_ready[1]), 32'(0));
      chk("p02_served", 32'(acc_rd_req_ready[0] | acc_rd_req_ready[2]), 32'(1));
      tick();
    end
    acc_rd_req_valid = '0;
    tick();
    chk("idle_port1_exhausted", 32'(idle), 32'(0));

    // Response routing and buffering behind a stalled port.
    do_reset();
    acc_rd_req_valid = 3'b001; drive_req_data(); tick();
    acc_rd_req_valid = 3'b100; drive_req_data(); tick();
    drive_req_data(); tick();
    acc_rd_req_valid = '0;
    repeat (2) tick();
    acc_rd_resp_ready = 3'b011;
    d1 = mk_resp(2);
    mem_rd_resp_valid = 1'b1;
    mem_rd_resp_data  = d1;
    tick();
    d2 = mk_resp(0);
    mem_rd_resp_data = d2;
    #1;
    chk("p2_valid_t1", 32'(acc_rd_resp_valid[2]), 32'(1));
    chk("p0_not_yet", 32'(acc_rd_resp_valid[0]), 32'(0));
    tick();
    d3 = mk_resp(2);
    mem_rd_resp_data = d3;
    #1;
    chk("p0_valid_t1", 32'(acc_rd_resp_valid[0]), 32'(1));
    chk_w("p0_data_t1", acc_rd_resp_data[0 +: SW], d2);
    chk("mem_resp_ready_held", 32'(mem_rd_resp_ready), 32'(1));
    tick();
    mem_rd_resp_valid = 1'b0;
    #1;
    chk("p0_popped", 32'(acc_rd_resp_valid[0]), 32'(0));
    for (int i = 0; i < 3; i++) begin
      chk("p2_hold_valid", 32'(acc_rd_resp_valid[2]), 32'(1));
      chk_w("p2_hold_data", acc_rd_resp_data[2*SW +: SW], d1);
      tick();
    end
    acc_rd_resp_ready = 3'b111;
    #1;
    chk_w("p2_first", acc_rd_resp_data[2*SW +: SW], d1);
    tick();
    chk("p2_second_valid", 32'(acc_rd_resp_valid[2]), 32'(1));
    chk_w("p2_second", acc_rd_resp_data[2*SW +: SW], d3);
    tick();
    chk("p2_empty", 32'(acc_rd_resp_valid[2]), 32'(0));
    chk("idle_after_return", 32'(idle), 32'(1));
    chk("resp_sb_drained", 32'(exp_resp_q[0].size() + exp_resp_q[2].size()), 32'(0));

    // Same-cycle accept and pop on port 0 with five credits left.
    do_reset();
    acc_rd_req_valid = 3'b001;
    for (int i = 0; i < 11; i++) begin
      drive_req_data();
      tick();
    end
    acc_rd_req_valid  = '0;
    repeat (2) tick();
    acc_rd_resp_ready = 3'b110;
    mem_rd_resp_data  = mk_resp(0);
    mem_rd_resp_valid = 1'b1;
    tick();
    mem_rd_resp_valid = 1'b0;
    tick();
    acc_rd_req_valid  = 3'b001;
    acc_rd_resp_ready = 3'b111;
    drive_req_data();
    #1;
    chk("same_cycle_req", 32'(acc_rd_req_ready[0]), 32'(1));
    chk("same_cycle_pop", 32'(acc_rd_resp_valid[0]), 32'(1));
    tick();
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      drive_req_data();
      #1;
      if (acc_rd_req_ready[0]) acc++;
      tick();
    end
    chk("credits_after_same_cycle", 32'(acc), 32'(5));
    acc_rd_req_valid = '0;
    tick();

    // Out-of-range response tag.
    do_reset();
    mem_rd_resp_data  = mk_resp(3);
    mem_rd_resp_valid = 1'b1;
    tick();
    mem_rd_resp_valid = 1'b0;
    #1;
    chk("bad_tag_no_valid", 32'(acc_rd_resp_valid), 32'(0));
    chk("bad_tag_err", 32'(tag_err), 32'(1));
    chk("bad_tag_idle", 32'(idle), 32'(1));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("tag_err_sticky", 32'(tag_err), 32'(1));
    end

    // Asynchronous reset with a held request and four outstanding.
    do_reset();
    acc_rd_req_valid = 3'b001;
    for (int i = 0; i < 4; i++) begin
      drive_req_data();
      tick();
    end
    mem_rd_req_ready = 1'b0;
    #1;
    chk("pre_reset_mem_valid", 32'(mem_rd_req_valid), 32'(1));
    chk("pre_reset_blocked", 32'(acc_rd_req_ready), 32'(0));
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mem_valid", 32'(mem_rd_req_valid), 32'(0));
    chk_w("rst_mem_data", SW'(mem_rd_req_data), '0);
    chk("rst_resp_ready", 32'(mem_rd_resp_ready), 32'(0));
    chk("rst_req_ready", 32'(acc_rd_req_ready), 32'(0));
    chk("rst_resp_valid", 32'(acc_rd_resp_valid), 32'(0));
    chk_w("rst_resp_data0", acc_rd_resp_data[0 +: SW], '0);
    chk("rst_idle", 32'(idle), 32'(1));
    chk("rst_tag_err", 32'(tag_err), 32'(0));
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    chk("release_resp_ready_low", 32'(mem_rd_resp_ready), 32'(0));
    tick();
    chk("release_resp_ready_high", 32'(mem_rd_resp_ready), 32'(1));
    chk("release_idle", 32'(idle), 32'(1));
    mem_rd_req_ready = 1'b1;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      drive_req_data();
      #1;
      if (acc_rd_req_ready[0]) acc++;
      tick();
    end
    chk("credits_after_reset", 32'(acc), 32'(MO));
    chk("idle_after_refill", 32'(idle), 32'(0));
    acc_rd_req_valid = '0;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
